// File: rtl/mem_byte_access_ctrl.sv
// Byte/halfword/word load-store controller for a 64x32 single-port RAM (read-modify-write for sub-word stores).
// Optional alignment checking with ERR response is built when MEM_ACC_ALIGN_CHK_EN is defined.
module mem_byte_access_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int RAM_LAT = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Req,
  input  logic              Wr,
  input  logic [1:0]        Size,
  input  logic              Unsigned,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       W_Data,
  output logic [31:0]       R_Data,
  output logic              Busy,
  output logic              Done,
  output logic              Err,
  output logic              Ram_We,
  output logic [ADDR_W-3:0] Ram_Addr,
  output logic [31:0]       Ram_Din,
  input  logic [31:0]       Ram_Dout
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
`ifdef MEM_ACC_ALIGN_CHK_EN
  localparam logic [2:0] ST_ERR   = 3'd5;
`endif

  logic [2:0]        state_r;
  logic [2:0]        next_s;
  logic              wr_r;
  logic [1:0]        size_r;
  logic              uns_r;
  logic [1:0]        lane_r;
  logic [31:0]       wdata_r;
  logic [1:0]        lat_cnt_r;
  logic [31:0]       r_data_r;
  logic              busy_r;
  logic              done_r;
  logic              ram_we_r;
  logic [ADDR_W-3:0] ram_addr_r;
  logic [31:0]       ram_din_r;
  logic              is_word_in_s;
  logic              is_half_in_s;
  logic [1:0]        lane_in_s;
`ifdef MEM_ACC_ALIGN_CHK_EN
  logic              misalign_s;
  logic              err_r;
`endif

  // Select the addressed lane of a RAM word and zero/sign-extend it.
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'b00:   b = w[7:0];
      2'b01:   b = w[15:8];
      2'b10:   b = w[23:16];
      2'b11:   b = w[31:24];
      default: b = 8'h00;
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   load_ext = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   load_ext = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: load_ext = w;
    endcase
  endfunction

  // Replace the addressed lane of the old RAM word with right-aligned store data.
  function automatic logic [31:0] merge_store(input logic [31:0] w, input logic [31:0] d,
                                              input logic [1:0] sz, input logic [1:0] lane);
    logic [31:0] m;
    m = w;
    case (sz)
      2'b00: begin
        case (lane)
          2'b00:   m[7:0]   = d[7:0];
          2'b01:   m[15:8]  = d[7:0];
          2'b10:   m[23:16] = d[7:0];
          2'b11:   m[31:24] = d[7:0];
          default: m = w;
        endcase
      end
      2'b01: begin
        if (lane[1]) m[31:16] = d[15:0];
        else         m[15:0]  = d[15:0];
      end
      default: m = d;
    endcase
    merge_store = m;
  endfunction

  // Decode the incoming request's size and effective lane.
  always_comb begin
    is_word_in_s = Size[1];
    is_half_in_s = (Size == 2'b01);
`ifdef MEM_ACC_ALIGN_CHK_EN
    lane_in_s  = Addr[1:0];
    misalign_s = (is_half_in_s && Addr[0]) || (is_word_in_s && (Addr[1:0] != 2'b00));
`else
    if (is_word_in_s)      lane_in_s = 2'b00;
    else if (is_half_in_s) lane_in_s = {Addr[1], 1'b0};
    else                   lane_in_s = Addr[1:0];
`endif
  end

  // Next-state logic.
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (Req) begin
          if (Wr && is_word_in_s) next_s = ST_WRITE;
          else                    next_s = ST_READ;
`ifdef MEM_ACC_ALIGN_CHK_EN
          if (misalign_s) next_s = ST_ERR;
          else            next_s = next_s;
`endif
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_READ: begin
        if (lat_cnt_r == 2'd0) next_s = ST_WAIT;
        else                   next_s = ST_READ;
      end
      ST_WAIT: begin
        if (wr_r) next_s = ST_WRITE;
        else      next_s = ST_DONE;
      end
      ST_WRITE: next_s = ST_DONE;
      ST_DONE:  next_s = ST_IDLE;
`ifdef MEM_ACC_ALIGN_CHK_EN
      ST_ERR:   next_s = ST_IDLE;
`endif
      default:  next_s = ST_IDLE;
    endcase
  end

  // State register and status outputs registered from the next state.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_r  <= ST_IDLE;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      ram_we_r <= 1'b0;
`ifdef MEM_ACC_ALIGN_CHK_EN
      err_r    <= 1'b0;
`endif
    end else begin
      state_r  <= next_s;
      busy_r   <= (next_s != ST_IDLE);
      ram_we_r <= (next_s == ST_WRITE);
`ifdef MEM_ACC_ALIGN_CHK_EN
      done_r   <= (next_s == ST_DONE) || (next_s == ST_ERR);
      err_r    <= (next_s == ST_ERR);
`else
      done_r   <= (next_s == ST_DONE);
`endif
    end
  end

  // Request latch, latency counter, load result and write-data/merge register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_r       <= 1'b0;
      size_r     <= 2'b00;
      uns_r      <= 1'b0;
      lane_r     <= 2'b00;
      wdata_r    <= 32'h0000_0000;
      lat_cnt_r  <= 2'd0;
      r_data_r   <= 32'h0000_0000;
      ram_addr_r <= '0;
      ram_din_r  <= 32'h0000_0000;
    end else begin
      if ((state_r == ST_IDLE) && Req) begin
        wr_r       <= Wr;
        size_r     <= Size;
        uns_r      <= Unsigned;
        lane_r     <= lane_in_s;
        wdata_r    <= W_Data;
        ram_addr_r <= Addr[ADDR_W-1:2];
        lat_cnt_r  <= 2'(RAM_LAT - 1);
      end else if ((state_r == ST_READ) && (lat_cnt_r != 2'd0)) begin
        lat_cnt_r <= lat_cnt_r - 2'd1;
      end else begin
        lat_cnt_r <= lat_cnt_r;
      end
      // Word stores skip the read and write the request data directly.
      if ((state_r == ST_IDLE) && (next_s == ST_WRITE)) begin
        ram_din_r <= W_Data;
      end else if ((state_r == ST_WAIT) && wr_r) begin
        ram_din_r <= merge_store(Ram_Dout, wdata_r, size_r, lane_r);
      end else begin
        ram_din_r <= ram_din_r;
      end
      if ((state_r == ST_WAIT) && !wr_r) r_data_r <= load_ext(Ram_Dout, size_r, lane_r, uns_r);
      else                               r_data_r <= r_data_r;
    end
  end

  assign R_Data   = r_data_r;
  assign Busy     = busy_r;
  assign Done     = done_r;
  assign Ram_We   = ram_we_r;
  assign Ram_Addr = ram_addr_r;
  assign Ram_Din  = ram_din_r;
`ifdef MEM_ACC_ALIGN_CHK_EN
  assign Err      = err_r;
`else
  assign Err      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_byte_access_ctrl.sv
// Directed self-checking bench for mem_byte_access_ctrl with a behavioural 64x32 RAM (latency 1).
module tb_mem_byte_access_ctrl;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Req;
  logic        Wr;
  logic [1:0]  Size;
  logic        Unsigned;
  logic [7:0]  Addr;
  logic [31:0] W_Data;
  logic [31:0] R_Data;
  logic        Busy;
  logic        Done;
  logic        Err;
  logic        Ram_We;
  logic [5:0]  Ram_Addr;
  logic [31:0] Ram_Din;
  logic [31:0] Ram_Dout;

  logic        pre_we;
  logic [5:0]  pre_addr;
  logic [31:0] pre_data;
  logic [31:0] mem [0:63];

  int cmp_cnt  = 0;
  int fail_cnt = 0;
  int we_cnt   = 0;
  int done_cnt = 0;

  mem_byte_access_ctrl #(.ADDR_W(8), .RAM_LAT(1)) dut (
    .Clk(Clk), .Rst(Rst), .Req(Req), .Wr(Wr), .Size(Size), .Unsigned(Unsigned),
    .Addr(Addr), .W_Data(W_Data), .R_Data(R_Data), .Busy(Busy), .Done(Done), .Err(Err),
    .Ram_We(Ram_We), .Ram_Addr(Ram_Addr), .Ram_Din(Ram_Din), .Ram_Dout(Ram_Dout)
  );

  always #5 Clk = ~Clk;

  // RAM with one-cycle registered read; bench preload port has priority.
  always @(posedge Clk) begin
    if (pre_we)      mem[pre_addr] <= pre_data;
    else if (Ram_We) mem[Ram_Addr] <= Ram_Din;
    Ram_Dout <= mem[Ram_Addr];
  end

  // Count write strobes and completion pulses.
  always @(posedge Clk) begin
    if (Ram_We) we_cnt <= we_cnt + 1;
    if (Done)   done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [5:0] a, input logic [31:0] d);
    @(negedge Clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge Clk);
    pre_we = 1'b0;
  endtask

  task automatic xact(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [7:0] a, input logic [31:0] wd, input int exp_lat,
                      input int exp_we_cyc, input logic [31:0] exp_din, input logic exp_err,
                      input logic [31:0] exp_rdata);
    int lat;
    int we_cyc;
    int we_base;
    logic [31:0] din;
    logic err;
    @(negedge Clk);
    we_base = we_cnt;
    Req = 1'b1; Wr = wr; Size = sz; Unsigned = uns; Addr = a; W_Data = wd;
    @(posedge Clk);
    @(negedge Clk);
    Req = 1'b0;
    lat = 0; we_cyc = 0; din = 32'h0; err = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (Ram_We && (we_cyc == 0)) begin
        we_cyc = c;
        din = Ram_Din;
      end
      if (Done) begin
        lat = c;
        err = Err;
        break;
      end
      @(negedge Clk);
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " we_cycle"}, 32'(we_cyc), 32'(exp_we_cyc));
    check({tag, " we_count"}, 32'(we_cnt - we_base), (exp_we_cyc != 0) ? 32'd1 : 32'd0);
    check({tag, " err"}, {31'd0, err}, {31'd0, exp_err});
    if (exp_we_cyc != 0) check({tag, " ram_din"}, din, exp_din);
    if (!wr) check({tag, " r_data"}, R_Data, exp_rdata);
  endtask

  initial begin
    int we_base;
    int done_base;
    Rst = 1'b1; Req = 1'b0; Wr = 1'b0; Size = 2'b00; Unsigned = 1'b0; Addr = 8'h00;
    W_Data = 32'h0; pre_we = 1'b0; pre_addr = 6'd0; pre_data = 32'h0;
    repeat (2) @(negedge Clk);
    check("rst r_data", R_Data, 32'h0);
    check("rst flags", {27'd0, Busy, Done, Err, Ram_We, 1'b0}, 32'h0);
    check("rst ram_addr", {26'd0, Ram_Addr}, 32'h0);
    check("rst ram_din", Ram_Din, 32'h0);
    Rst = 1'b0;

    preload(6'd1, 32'h1234_5678);
    preload(6'd2, 32'h0000_FF80);
    preload(6'd15, 32'h0000_0000);

    xact("ld_b_u_05", 1'b0, 2'b00, 1'b1, 8'h05, 32'h0, 3, 0, 32'h0, 1'b0, 32'h0000_0056);
    xact("ld_b_s_08", 1'b0, 2'b00, 1'b0, 8'h08, 32'h0, 3, 0, 32'h0, 1'b0, 32'hFFFF_FF80);
    xact("ld_h_s_08", 1'b0, 2'b01, 1'b0, 8'h08, 32'h0, 3, 0, 32'h0, 1'b0, 32'hFFFF_FF80);
    xact("ld_h_u_0A", 1'b0, 2'b01, 1'b1, 8'h0A, 32'h0, 3, 0, 32'h0, 1'b0, 32'h0000_0000);

    xact("st_b_07", 1'b1, 2'b00, 1'b0, 8'h07, 32'h0000_00AB, 4, 3, 32'hAB34_5678, 1'b0, 32'h0);
    xact("ld_w_04", 1'b0, 2'b10, 1'b0, 8'h04, 32'h0, 3, 0, 32'h0, 1'b0, 32'hAB34_5678);
    xact("ld_w11_04", 1'b0, 2'b11, 1'b1, 8'h04, 32'h0, 3, 0, 32'h0, 1'b0, 32'hAB34_5678);
    xact("ld_b_s_07", 1'b0, 2'b00, 1'b0, 8'h07, 32'h0, 3, 0, 32'h0, 1'b0, 32'hFFFF_FFAB);

    xact("st_w_3C", 1'b1, 2'b10, 1'b0, 8'h3C, 32'hFFFF_FFFF, 2, 1, 32'hFFFF_FFFF, 1'b0, 32'h0);
    xact("st_h_3E", 1'b1, 2'b01, 1'b0, 8'h3E, 32'h0000_2FFF, 4, 3, 32'h2FFF_FFFF, 1'b0, 32'h0);
    xact("ld_w_3C", 1'b0, 2'b10, 1'b0, 8'h3C, 32'h0, 3, 0, 32'h0, 1'b0, 32'h2FFF_FFFF);

`ifdef MEM_ACC_ALIGN_CHK_EN
    xact("ld_h_05", 1'b0, 2'b01, 1'b1, 8'h05, 32'h0, 1, 0, 32'h0, 1'b1, 32'h2FFF_FFFF);
`else
    xact("ld_h_05", 1'b0, 2'b01, 1'b1, 8'h05, 32'h0, 3, 0, 32'h0, 1'b0, 32'h0000_5678);
`endif

    // Reset asserted while a byte store sits in WAIT.
    @(negedge Clk);
    Req = 1'b1; Wr = 1'b1; Size = 2'b00; Unsigned = 1'b0; Addr = 8'h09; W_Data = 32'h0000_0011;
    @(posedge Clk);
    @(negedge Clk);
    Req = 1'b0;
    @(negedge Clk);
    check("abort busy_before", {31'd0, Busy}, 32'd1);
    Rst = 1'b1;
    #1;
    check("abort r_data", R_Data, 32'h0);
    check("abort flags", {27'd0, Busy, Done, Err, Ram_We, 1'b0}, 32'h0);
    check("abort ram_addr", {26'd0, Ram_Addr}, 32'h0);
    check("abort ram_din", Ram_Din, 32'h0);
    @(negedge Clk);
    Rst = 1'b0;
    we_base = we_cnt;
    repeat (8) @(negedge Clk);
    check("abort no_write", 32'(we_cnt - we_base), 32'd0);
    xact("ld_w_08", 1'b0, 2'b10, 1'b0, 8'h08, 32'h0, 3, 0, 32'h0, 1'b0, 32'h0000_FF80);

    // A store request pulsed while busy with a load must be ignored.
    @(negedge Clk);
    we_base = we_cnt;
    done_base = done_cnt;
    Req = 1'b1; Wr = 1'b0; Size = 2'b10; Unsigned = 1'b0; Addr = 8'h04; W_Data = 32'h0;
    @(posedge Clk);
    @(negedge Clk);
    Req = 1'b0;
    @(negedge Clk);
    Req = 1'b1; Wr = 1'b1; Size = 2'b10; Addr = 8'h04; W_Data = 32'hDEAD_BEEF;
    @(negedge Clk);
    Req = 1'b0;
    repeat (10) @(negedge Clk);
    check("busy_req done_count", 32'(done_cnt - done_base), 32'd1);
    check("busy_req no_write", 32'(we_cnt - we_base), 32'd0);
    check("busy_req r_data", R_Data, 32'hAB34_5678);
    xact("ld_w_04_after", 1'b0, 2'b10, 1'b0, 8'h04, 32'h0, 3, 0, 32'h0, 1'b0, 32'hAB34_5678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/mem_byte_access_ctrl.md
Name: mem_byte_access_ctrl

Overview:
- Byte/halfword/word load-store controller between a requester (CPU datapath or test sequencer) and the 64x32 single-port data RAM.
- RAM has one whole-word write enable, so sub-word stores use read-modify-write.
- Sub-word loads are lane-selected and zero- or sign-extended.
- Lane order is little-endian: byte address [1:0]=00 selects bits [7:0], 11 selects bits [31:24].

Parameters:
- ADDR_W, 8: requester byte-address width; RAM word address is ADDR_W-2 bits.
- RAM_LAT, 1: RAM read latency in clocks, from address sampled to Ram_Dout valid; legal values 1..3.

Ports:
- Clk  input  1  system clock, rising edge.
- Rst  input  1  asynchronous, active-high reset.
- Req  input  1  request strobe; sampled only in IDLE.
- Wr  input  1  1 = store, 0 = load.
- Size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
- Unsigned  input  1  load extension: 1 zero-extend, 0 sign-extend.
- Addr  input  ADDR_W  byte address.
- W_Data  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- R_Data  output  32  load result, registered; valid when Done=1 for a load.
- Busy  output  1  high whenever state is not IDLE.
- Done  output  1  one-cycle completion pulse.
- Err  output  1  one-cycle pulse with Done on a misaligned request.
- Ram_We  output  1  RAM write enable.
- Ram_Addr  output  ADDR_W-2  RAM word address, registered.
- Ram_Din  output  32  RAM write data.
- Ram_Dout  input  32  RAM read data.

Behaviour:
- Reset (asynchronous): state IDLE; R_Data=0, Busy=0, Done=0, Err=0, Ram_We=0, Ram_Addr=0, Ram_Din=0. Latched request fields, merge register and latency counter all cleared.
- States: IDLE, READ, WAIT, WRITE, DONE, ERR.
- IDLE:
  - On Req=1 at an edge: latch Wr, Size, Unsigned, Addr, W_Data. Ram_Addr <= Addr[ADDR_W-1:2].
  - Misaligned request (half with Addr[0]=1, or word with Addr[1:0]!=0) -> ERR.
  - Word store -> WRITE (no read).
  - Any other request -> READ.
  - Req while Busy=1 is ignored; the requester must hold Req until it sees Busy=1 or Done=1.
- READ: stays RAM_LAT cycles (down-counter), then -> WAIT. Ram_We=0.
- WAIT: Ram_Dout is valid in this state.
  - Load: R_Data <= selected lane, extended per Unsigned (word ignores Unsigned); -> DONE.
  - Sub-word store: merge register <= Ram_Dout with the addressed lane replaced by the W_Data low bits; other lanes unchanged; -> WRITE.
- WRITE: Ram_We=1 for exactly one cycle; Ram_Din = merge register, or latched W_Data for a word store; -> DONE.
- DONE: Done=1 for one cycle -> IDLE. Req may be accepted at the edge that leaves DONE's following IDLE cycle; there are no back-to-back acceptances in DONE.
- ERR: Done=1 and Err=1 for one cycle; no RAM write; R_Data unchanged; -> IDLE.
- Latency, counted from the accepting edge to Done high (RAM_LAT=1):
  - load: RAM_LAT+2 = 3 cycles.
  - sub-word store: RAM_LAT+3 = 4 cycles.
  - word store: 2 cycles.
  - error: 1 cycle.
- Ram_We is 0 in every state except WRITE. A store issues exactly one write per request.
- Reset mid-operation aborts immediately: no write is issued after reset deasserts, and the RAM word is left as it was before the request.
- Size=11 behaves exactly as Size=10.
- Top-of-memory address (all ones) needs no special handling; there is no wrap beyond the word.

Optional Feature:
- Macro MEM_ACC_ALIGN_CHK_EN.
- Defined: misaligned requests go to ERR as described above.
- Undefined: no alignment check. Addr[0] is ignored for halfwords and Addr[1:0] for words (forced to 0). The ERR state is not built and Err is tied to 0.

Test Plan:
- Preload word 1 = 0x12345678; load byte, Unsigned=1, Addr=0x05 -> Done at cycle 3, R_Data=0x00000056, Ram_We never high.
- Preload word 2 = 0x0000FF80; load byte, signed, Addr=0x08 -> R_Data=0xFFFFFF80; load half, signed, Addr=0x08 -> 0xFFFFFF80; load half, Unsigned=1, Addr=0x0A -> 0x00000000.
- Word 1 = 0x12345678; store byte W_Data=0x000000AB at Addr=0x07 -> single Ram_We pulse at cycle 3, Ram_Din=0xAB345678; readback word load -> 0xAB345678.
- Store word 0xFFFFFFFF at Addr=0x3C -> Ram_We at cycle 1, Done at cycle 2, no READ state; store half 0x2FFF at Addr=0x3E -> word becomes 0x2FFFFFFF.
- With MEM_ACC_ALIGN_CHK_EN: load half at Addr=0x05 -> Done=Err=1 at cycle 1, R_Data unchanged. Without the macro: the same request returns the half at 0x04 with Err=0.
- Assert Rst during the WAIT state of a byte store -> all outputs 0 immediately, no Ram_We pulse afterwards, target word unchanged. Req pulsed while Busy=1 -> ignored, with exactly one Done per accepted request.
